uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, 2..256.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock for all logic; rising edge active.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 rx_ready  input  1  receiver byte-complete flag; level signal, qualified by rising edge.
REQ-007 rd_en  input  1  consumer read request, one byte per cycle.
REQ-008 ovf_clr  input  1  clears the sticky overflow flag.
REQ-009 rd_data  output  8  byte popped by an accepted read.
REQ-010 rd_valid  output  1  one-cycle pulse; rd_data is valid in that cycle.
REQ-011 empty  output  1  high when count == 0.
REQ-012 full  output  1  high when count == DEPTH.
REQ-013 count  output  AW+1  number of stored bytes, 0..DEPTH.
REQ-014 overflow  output  1  sticky flag; a byte was dropped.

Function
REQ-015 Write strobe wr = rx_ready & ~rx_ready_q, where rx_ready_q is rx_ready registered one cycle; exactly one write per rising edge of rx_ready, regardless of how long it stays high.
REQ-016 wr with full == 0 SHALL store rx_data at wr_ptr and increment wr_ptr modulo DEPTH.
REQ-017 Read accepted = rd_en & ~empty; it SHALL register mem[rd_ptr] into rd_data, assert rd_valid the next cycle, and increment rd_ptr modulo DEPTH.
REQ-018 Read latency SHALL be exactly 1 cycle from rd_en sampled high to rd_valid high; no fall-through.
REQ-019 rd_en while empty SHALL be ignored: rd_valid = 0, rd_data holds, pointers unchanged.
REQ-020 Write and accepted read in the same cycle SHALL both proceed; count unchanged.
REQ-021 wr while full with an accepted read in the same cycle SHALL store the byte (no drop, no overflow).
REQ-022 wr while full without a read SHALL drop the byte, leave memory, pointers and count unchanged, and set overflow.
REQ-023 wr while empty with rd_en high in the same cycle: write only; read ignored (see REQ-019).
REQ-024 overflow SHALL stay set until a cycle with ovf_clr = 1; a drop in the same cycle as ovf_clr leaves overflow = 1 (set wins).
REQ-025 Pointers SHALL be AW bits and wrap DEPTH-1 -> 0; count, empty and full are registered and exact at wrap.
REQ-026 count SHALL change by +1 on write only, -1 on read only, and 0 on both or neither.

Reset
REQ-027 With rst high at a clock edge, the block SHALL set wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0, rd_valid = 0, rd_data = 8'h00, and rx_ready_q = 0.
REQ-028 rst SHALL take priority over every simultaneous wr, rd_en or ovf_clr; reset mid-operation SHALL discard stored data, and memory contents need not be cleared.
REQ-029 If rx_ready is already high when rst deasserts, the first non-reset cycle SHALL see a rising edge and write once.

Verification
REQ-030 Reset, then pulse rx_ready with rx_data = 8'hA5 -> count = 1, empty = 0; rd_en for 1 cycle -> next cycle rd_valid = 1, rd_data = 8'hA5, empty = 1.
REQ-031 Hold rx_ready high for 5 cycles with rx_data = 8'h3C -> exactly one entry stored, count = 1.
REQ-032 Write 16 bytes 8'h00..8'h0F -> full = 1, count = 16; a 17th byte 8'hFF -> overflow = 1, count = 16; read all 16 -> 8'h00..8'h0F in order; ovf_clr -> overflow = 0.
REQ-033 With full = 1, a write of 8'h77 and rd_en in the same cycle -> rd_data = oldest byte, count stays 16, overflow stays 0, and 8'h77 is read last.
REQ-034 Write and read 40 bytes in steady alternation -> pointers wrap twice, data in order, and count never exceeds 1.
REQ-035 Assert rst with count = 7 -> the next cycle shows count = 0, empty = 1, overflow = 0, and rd_en produces no rd_valid.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO placed behind a UART receiver.
//
// The FIFO writes one byte on each rising edge of rx_ready. Reads are
// registered. An accepted rd_en returns rd_data together with a one-cycle
// rd_valid pulse in the following cycle. A byte that arrives while the FIFO
// is full is dropped, and the sticky overflow flag is set, unless a read is
// accepted in the same cycle.
//
// Ports:
//   clk       rising-edge clock for all logic
//   rst       synchronous, active-high reset
//   rx_data   received byte
//   rx_ready  byte-complete level from the receiver; its rising edge writes
//   rd_en     read request, one byte per cycle
//   ovf_clr   clears overflow (a simultaneous drop wins)
//   rd_data   byte popped by the last accepted read
//   rd_valid  one-cycle pulse marking rd_data valid
//   empty     count == 0
//   full      count == DEPTH
//   count     number of stored bytes, 0..DEPTH
//   overflow  sticky flag: a byte was dropped
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_ready,
    input  logic          rd_en,
    input  logic          ovf_clr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];

    logic          rx_ready_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    rd_data_q;
    logic          rd_valid_q;

    logic          wr;
    logic          rd_acc;
    logic          do_write;
    logic          drop;

    // Edge-detect rx_ready so that a long-held level writes only once.
    assign wr       = rx_ready & ~rx_ready_q;
    assign rd_acc   = rd_en & ~empty_q;
    // When the FIFO is full, a read in the same cycle frees the slot the write needs.
    assign do_write = wr & (~full_q | rd_acc);
    assign drop     = wr & full_q & ~rd_acc;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (do_write) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({do_write, rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // A drop takes priority over the clear.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == DepthCnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
        end else begin
            rx_ready_q <= rx_ready;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end
    end

    // Storage is not reset. Reset only clears the pointers. When the FIFO is
    // full, both pointers address the same slot, so a simultaneous read still
    // returns the old byte.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH = 16).
// The bench drives inputs #1 after a rising edge and samples outputs at the same point.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       rd_en;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    uart_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes one byte with a one-cycle rx_ready pulse, then leaves one low cycle.
    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_ready = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; rx_data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rd_data); end
    endtask

    task automatic test_basic();
        push(8'hA5);
        total++; if (count !== 5'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", count); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", rd_valid); end
        total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", rd_data); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_empty2 got=%b exp=1", empty); end
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", rd_valid); end
    endtask

    task automatic test_hold();
        rx_data  = 8'h3C;
        rx_ready = 1'b1;
        repeat (5) tick();
        rx_ready = 1'b0;
        tick();
        total++; if (count !== 5'd1) begin bad++; $display("FAIL hold_count got=%0d exp=1", count); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++; if (rd_data !== 8'h3C) begin bad++; $display("FAIL hold_data got=%h exp=3c", rd_data); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL hold_drain got=%0d exp=0", count); end
    endtask

    task automatic test_empty_read();
        push(8'h61);
        rd_en = 1'b1;
        tick();
        total++; if (rd_data !== 8'h61) begin bad++; $display("FAIL er_pre got=%h exp=61", rd_data); end
        // The FIFO is now empty, so this rd_en must be ignored.
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL er_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 8'h61) begin bad++; $display("FAIL er_hold got=%h exp=61", rd_data); end
        // Write while empty with rd_en high: write only.
        rx_data = 8'h5A; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0; rd_en = 1'b0;
        total++; if (count !== 5'd1) begin bad++; $display("FAIL er_wr_count got=%0d exp=1", count); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL er_wr_valid got=%b exp=0", rd_valid); end
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++; if (rd_data !== 8'h5A || rd_valid !== 1'b1) begin
            bad++; $display("FAIL er_data got=%h/%b exp=5a/1", rd_data, rd_valid);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b exp=1", full); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d exp=16", count); end
        push(8'hFF);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b exp=1", overflow); end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count2 got=%0d exp=16", count); end
        // A drop in the same cycle as ovf_clr must leave overflow set.
        rx_data = 8'hEE; rx_ready = 1'b1; ovf_clr = 1'b1;
        tick();
        rx_ready = 1'b0; ovf_clr = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL set_wins got=%b exp=1", overflow); end
        tick();
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                bad++; $display("FAIL full_read%0d got=%h/%b exp=%h/1", i, rd_data, rd_valid, 8'(i));
            end
        end
        rd_en = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_empty got=%b exp=1", empty); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        rx_data = 8'h77; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_ready = 1'b0; rd_en = 1'b0;
        total++; if (rd_valid !== 1'b1 || rd_data !== 8'h10) begin
            bad++; $display("FAIL frw_data got=%h/%b exp=10/1", rd_data, rd_valid);
        end
        total++; if (count !== 5'd16) begin bad++; $display("FAIL frw_count got=%0d exp=16", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL frw_ovf got=%b exp=0", overflow); end
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [7:0] exp_b;
            exp_b = (i == 15) ? 8'h77 : 8'h11 + 8'(i);
            tick();
            total++; if (rd_data !== exp_b) begin
                bad++; $display("FAIL frw_read%0d got=%h exp=%h", i, rd_data, exp_b);
            end
        end
        rd_en = 1'b0;
        tick();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL frw_empty got=%b exp=1", empty); end
    endtask

    task automatic test_alternate();
        int max_cnt = 0;
        int errs = 0;
        for (int i = 0; i < 40; i++) begin
            push(8'h40 + 8'(i));
            if (int'(count) > max_cnt) max_cnt = int'(count);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            if (rd_valid !== 1'b1 || rd_data !== 8'h40 + 8'(i)) begin
                errs++;
                $display("FAIL alt%0d got=%h/%b exp=%h/1", i, rd_data, rd_valid, 8'h40 + 8'(i));
            end
        end
        total++; if (errs != 0) bad++;
        total++; if (max_cnt != 1) begin bad++; $display("FAIL alt_max got=%0d exp=1", max_cnt); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL alt_empty got=%b exp=1", empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) push(8'h90 + 8'(i));
        total++; if (count !== 5'd7) begin bad++; $display("FAIL rm_pre got=%0d exp=7", count); end
        rst = 1'b1; rd_en = 1'b1;
        tick();
        rst = 1'b0; rd_en = 1'b0;
        total++; if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL rm_state got=%0d/%b/%b exp=0/1/0", count, empty, overflow);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", rd_valid); end
    endtask

    task automatic test_ready_at_reset();
        rst = 1'b1; rx_ready = 1'b1; rx_data = 8'hC3;
        tick();
        total++; if (count !== 5'd0) begin bad++; $display("FAIL rr_in_rst got=%0d exp=0", count); end
        rst = 1'b0;
        tick();
        total++; if (count !== 5'd1) begin bad++; $display("FAIL rr_count got=%0d exp=1", count); end
        tick();
        total++; if (count !== 5'd1) begin bad++; $display("FAIL rr_once got=%0d exp=1", count); end
        rx_ready = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++; if (rd_data !== 8'hC3) begin bad++; $display("FAIL rr_data got=%h exp=c3", rd_data); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_empty_read();
        test_full();
        test_full_rw();
        test_alternate();
        test_reset_mid();
        test_ready_at_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
